// File: rtl/acs_scheduler.sv
// Viterbi ACS scheduler: walks NUM_ACS-wide butterfly groups over the trellis once per accepted step.
// Optional path-metric normalization sequencing is enabled by defining ACS_SCHED_NORM_EN.
module acs_scheduler #(
  parameter int K        = 7,
  parameter int NUM_ACS  = 4,
  parameter int RD_LAT   = 1,
  parameter int TB_DEPTH = 64,
  parameter int PM_WIDTH = 12
) (
  input  logic                                      clock,
  input  logic                                      reset_n,
  input  logic                                      step_valid,
  input  logic                                      frame_start,
  output logic                                      step_ready,
  output logic                                      pm_init,
  output logic [K-3:0]                              bfly_base,
  output logic                                      pm_rd_en,
  output logic [(((2**(K-2))/NUM_ACS) > 1 ? $clog2((2**(K-2))/NUM_ACS) : 1)-1:0] pm_rd_addr,
  output logic                                      pm_rd_bank,
  output logic                                      acs_valid,
  output logic                                      pm_wr_en,
  output logic [(((2**(K-2))/NUM_ACS) > 1 ? $clog2((2**(K-2))/NUM_ACS) : 1)-1:0] pm_wr_addr,
  output logic                                      ph_wr_en,
  output logic [$clog2(TB_DEPTH)+(((2**(K-2))/NUM_ACS) > 1 ? $clog2((2**(K-2))/NUM_ACS) : 1)-1:0] ph_wr_addr,
  output logic [$clog2(TB_DEPTH)-1:0]               step_ptr,
  output logic                                      step_done,
  input  logic                                      acs_pm_msb,
  output logic                                      norm_sub
);

  localparam int NUM_BFLY = 2 ** (K - 2);
  localparam int NG       = NUM_BFLY / NUM_ACS;
  localparam int GW       = (NG > 1) ? $clog2(NG) : 1;
  localparam int TW       = $clog2(TB_DEPTH);
  localparam int BW       = K - 2;
  localparam int DW       = $clog2(RD_LAT + 2);
  localparam int unused_pm_width = PM_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SWAP} state_t;

  state_t          state;
  logic [DW-1:0]   drain_cnt;
  logic            frame_r;
  logic            accept;
  logic            issue_last;
  logic [GW-1:0]   next_addr;

  logic [RD_LAT:0]          vld_pipe;
  logic [RD_LAT:0][GW-1:0]  addr_pipe;
  logic [RD_LAT-1:0]        init_pipe;

  assign accept     = (state == IDLE) && step_valid && step_ready;
  assign issue_last = (state == ISSUE) && (pm_rd_addr == GW'(NG - 1));
  assign next_addr  = pm_rd_addr + GW'(1);

  // Step sequencer: issues one read per group, drains the RAM/ACS pipeline, then swaps banks.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      step_ready <= 1'b0;
      pm_rd_en   <= 1'b0;
      pm_rd_addr <= '0;
      bfly_base  <= '0;
      pm_rd_bank <= 1'b0;
      step_ptr   <= '0;
      step_done  <= 1'b0;
      drain_cnt  <= '0;
      frame_r    <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= ISSUE;
            step_ready <= 1'b0;
            pm_rd_en   <= 1'b1;
            pm_rd_addr <= '0;
            bfly_base  <= '0;
            frame_r    <= frame_start;
            if (frame_start) begin
              pm_rd_bank <= 1'b0;
              step_ptr   <= '0;
            end
          end else begin
            step_ready <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_last) begin
            state      <= DRAIN;
            pm_rd_en   <= 1'b0;
            pm_rd_addr <= '0;
            bfly_base  <= '0;
            drain_cnt  <= '0;
          end else begin
            pm_rd_addr <= next_addr;
            bfly_base  <= BW'(next_addr) * BW'(NUM_ACS);
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(RD_LAT)) begin
            state     <= SWAP;
            step_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        SWAP: begin
          state      <= IDLE;
          step_ready <= 1'b1;
          pm_rd_bank <= ~pm_rd_bank;
          step_ptr   <= step_ptr + TW'(1);
        end
        default: begin
          state      <= IDLE;
          step_ready <= 1'b0;
          pm_rd_en   <= 1'b0;
        end
      endcase
    end
  end

  // Read-to-ACS-to-write alignment: acs_valid trails the read by RD_LAT, writes by one more.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
      init_pipe <= '0;
    end else begin
      vld_pipe[0]  <= pm_rd_en;
      addr_pipe[0] <= pm_rd_addr;
      init_pipe[0] <= pm_rd_en & frame_r;
      for (int i = 1; i <= RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        init_pipe[i] <= init_pipe[i-1];
      end
    end
  end

  assign acs_valid  = vld_pipe[RD_LAT-1];
  assign pm_init    = init_pipe[RD_LAT-1];
  assign pm_wr_en   = vld_pipe[RD_LAT];
  assign ph_wr_en   = vld_pipe[RD_LAT];
  assign pm_wr_addr = addr_pipe[RD_LAT];
  assign ph_wr_addr = {step_ptr, addr_pipe[RD_LAT]};

`ifdef ACS_SCHED_NORM_EN
  logic              norm_flag;
  logic              norm_pending;
  logic [RD_LAT-1:0] norm_pipe;

  // Any PM MSB seen while writing step n arms a subtract on every ACS cycle of step n+1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      norm_flag    <= 1'b0;
      norm_pending <= 1'b0;
      norm_pipe    <= '0;
    end else begin
      norm_pipe[0] <= pm_rd_en & norm_pending;
      for (int i = 1; i < RD_LAT; i++) begin
        norm_pipe[i] <= norm_pipe[i-1];
      end
      if (accept && frame_start) begin
        norm_flag    <= 1'b0;
        norm_pending <= 1'b0;
      end else if (state == SWAP) begin
        norm_pending <= norm_flag;
        norm_flag    <= 1'b0;
      end else begin
        if (pm_wr_en && acs_pm_msb) begin
          norm_flag <= 1'b1;
        end
        if (issue_last) begin
          norm_pending <= 1'b0;
        end
      end
    end
  end

  assign norm_sub = norm_pipe[RD_LAT-1];
`else
  logic unused_msb;
  assign unused_msb = acs_pm_msb;
  assign norm_sub   = 1'b0;
`endif

endmodule

// File: tb/tb_acs_scheduler.sv
// Self-checking bench for acs_scheduler: table-driven steps with per-cycle timing checks and a write scoreboard.
module tb_acs_scheduler;

  localparam int K = 7, NUM_ACS = 4, RD_LAT = 1, TB_DEPTH = 64, PM_WIDTH = 12;
  localparam int NG = 8, GW = 3, TW = 6;
`ifdef ACS_SCHED_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n, step_valid, frame_start, acs_pm_msb;
  logic             step_ready, pm_init, pm_rd_en, pm_rd_bank, acs_valid;
  logic             pm_wr_en, ph_wr_en, step_done, norm_sub;
  logic [K-3:0]     bfly_base;
  logic [GW-1:0]    pm_rd_addr, pm_wr_addr;
  logic [TW+GW-1:0] ph_wr_addr;
  logic [TW-1:0]    step_ptr;

  acs_scheduler #(.K(K), .NUM_ACS(NUM_ACS), .RD_LAT(RD_LAT), .TB_DEPTH(TB_DEPTH), .PM_WIDTH(PM_WIDTH)) dut (
    .clock(clock), .reset_n(reset_n), .step_valid(step_valid), .frame_start(frame_start),
    .step_ready(step_ready), .pm_init(pm_init), .bfly_base(bfly_base), .pm_rd_en(pm_rd_en),
    .pm_rd_addr(pm_rd_addr), .pm_rd_bank(pm_rd_bank), .acs_valid(acs_valid), .pm_wr_en(pm_wr_en),
    .pm_wr_addr(pm_wr_addr), .ph_wr_en(ph_wr_en), .ph_wr_addr(ph_wr_addr), .step_ptr(step_ptr),
    .step_done(step_done), .acs_pm_msb(acs_pm_msb), .norm_sub(norm_sub)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit frame;
    int msb_k;
    int ptr;
    bit bank;
    bit init;
    bit norm;
    bit hold;
  } vec_t;

  typedef struct {
    logic [GW-1:0]    a;
    logic [TW+GW-1:0] ph;
  } wr_t;

  wr_t  sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Write scoreboard: every PM/PH write must match the next queued {group, {step_ptr, group}}.
  always @(negedge clock) begin : sb_chk
    wr_t e;
    if (pm_wr_en === 1'b1) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("pm_wr_addr", pm_wr_addr, e.a);
        chk("ph_wr_addr", ph_wr_addr, e.ph);
      end
    end
  end

  task automatic push_step(input int ptr);
    for (int g = 0; g < NG; g++) sb.push_back('{g[GW-1:0], {ptr[TW-1:0], g[GW-1:0]}});
  endtask

  task automatic run_step(input bit frame, input int msb_k, input int ptr, input bit bank,
                          input bit init, input bit norm, input bit hold);
    int  w;
    bit  rd, av, wr;
    w = 0;
    while (step_ready !== 1'b1 && w < 30) begin
      @(negedge clock);
      w++;
    end
    if (step_ready !== 1'b1) begin
      chk("ready_timeout", step_ready, 1);
      return;
    end
    step_valid  = 1'b1;
    frame_start = frame;
    push_step(ptr);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      step_valid  = hold && (k < 11);
      frame_start = 1'b0;
      acs_pm_msb  = (k == msb_k);
      rd = (k >= 1) && (k <= NG);
      av = (k >= 2) && (k <= NG + 1);
      wr = (k >= 3) && (k <= NG + 2);
      chk("pm_rd_en", pm_rd_en, rd);
      if (rd) begin
        chk("pm_rd_addr", pm_rd_addr, k - 1);
        chk("bfly_base", bfly_base, (k - 1) * NUM_ACS);
        chk("pm_rd_bank", pm_rd_bank, bank);
      end
      chk("acs_valid", acs_valid, av);
      chk("pm_init", pm_init, av && init);
      chk("norm_sub", norm_sub, av && norm && NORM);
      chk("pm_wr_en", pm_wr_en, wr);
      chk("ph_wr_en", ph_wr_en, wr);
      chk("step_done", step_done, k == 11);
      chk("step_ready", step_ready, k == 12);
      chk("step_ptr", step_ptr, (k == 12) ? (ptr + 1) % TB_DEPTH : ptr);
      if (k == 12) chk("bank_swap", pm_rd_bank, !bank);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    int   m_ptr, msbk;
    bit   m_bank, m_pend;

    tbl[0] = '{1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 6, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 0, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1, 3, 1'b1, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0; step_valid = 1'b0; frame_start = 1'b0; acs_pm_msb = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_strobes", {step_ready, pm_init, pm_rd_en, acs_valid, pm_wr_en, ph_wr_en, step_done, norm_sub}, 0);
    chk("reset_addrs", {pm_rd_addr, pm_wr_addr, bfly_base, ph_wr_addr}, 0);
    chk("reset_bank_ptr", {pm_rd_bank, step_ptr}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", step_ready, 1);

    for (int i = 0; i < 4; i++)
      run_step(tbl[i].frame, tbl[i].msb_k, tbl[i].ptr, tbl[i].bank, tbl[i].init, tbl[i].norm, tbl[i].hold);

    m_ptr = 4; m_bank = 1'b0; m_pend = 1'b0;
    for (int i = 0; i < 97; i++) begin
      msbk = (i == 96) ? 5 : 0;
      run_step(1'b0, msbk, m_ptr, m_bank, 1'b0, m_pend, 1'b0);
      m_pend = (msbk != 0);
      m_ptr  = (m_ptr + 1) % TB_DEPTH;
      m_bank = !m_bank;
    end
    chk("ptr_before_frame", step_ptr, 37);
    chk("bank_before_frame", pm_rd_bank, 1);

    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    @(negedge clock);
    chk("lone_frame_ptr", step_ptr, m_ptr);
    chk("lone_frame_bank", pm_rd_bank, m_bank);
    chk("lone_frame_rd", pm_rd_en, 0);

    run_step(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_step(1'b0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort a step with reset in its sixth cycle.
    step_valid = 1'b1;
    push_step(2);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      step_valid = 1'b0;
      if (k == 6 || k == 7)
        chk("abort_strobes", {pm_rd_en, acs_valid, pm_wr_en, ph_wr_en, step_done, step_ready, pm_init, norm_sub}, 0);
      if (k == 5) reset_n = 1'b0;
      if (k == 7) reset_n = 1'b1;
    end
    chk("abort_ready", step_ready, 1);
    chk("abort_bank", pm_rd_bank, 0);
    chk("abort_ptr", step_ptr, 0);
    chk("abort_sb_left", sb.size(), 5);
    sb.delete();

    run_step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
